// File: rtl/det_pkg.sv
// Shared types and constants for the Bareiss determinant engine.
package det_pkg;

  // Top-level sequencing states, listed in the order a run visits them.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    PIVOT,
    SWAP,
    ELIM,
    DIV,
    DONE
  } state_e;

  // Sequential divider states: operand setup, iteration, sign fix-up.
  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX
  } div_state_e;

  localparam int NMAX_DEFAULT = 8;

  // The header word carries the matrix order N; legal values are HDR_MIN_N..NMAX.
  localparam int HDR_MIN_N = 1;

  // Width of a row/column index into the NMAX x NMAX buffer.
  function automatic int idx_width(input int nmax);
    return (nmax > 1) ? $clog2(nmax) : 1;
  endfunction

  localparam int IDX_W = idx_width(NMAX_DEFAULT);

endpackage

// File: rtl/det_div.sv
// Signed sequential restoring divider: 2*OUT_W dividend / OUT_W divisor.
// Two quotient bits are resolved per cycle so the full double-width quotient
// is produced in OUT_W iterations; the result is truncated to OUT_W bits and
// rounds toward zero. A divide occupies OUT_W+2 cycles including setup and
// sign fix-up, and done pulses for one cycle when quotient is valid.
module det_div
  import det_pkg::*;
#(
  parameter int OUT_W = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*OUT_W-1:0] dividend,
  input  logic [OUT_W-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   quotient
);

  localparam int PW = 2 * OUT_W;
  localparam int CW = $clog2(OUT_W) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(OUT_W - 1);

  div_state_e       state_q, state_d;
  logic [PW-1:0]    num_q, num_d;
  logic [OUT_W-1:0] den_q, den_d;
  logic [OUT_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0] quo_q, quo_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W:0]   trial;

  // Next-state logic: magnitude setup, two restoring steps per cycle, sign fix.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    trial   = '0;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          neg_d   = dividend[PW-1] ^ divisor[OUT_W-1];
          num_d   = dividend[PW-1] ? -dividend : dividend;
          den_d   = divisor[OUT_W-1] ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        for (int s = 0; s < 2; s++) begin
          trial = {rem_d, num_d[PW-1]};
          num_d = {num_d[PW-2:0], 1'b0};
          if (trial >= {1'b0, den_q}) begin
            trial    = trial - {1'b0, den_q};
            num_d[0] = 1'b1;
          end
          rem_d = trial[OUT_W-1:0];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        quo_d   = neg_q ? -num_q[OUT_W-1:0] : num_q[OUT_W-1:0];
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != DIV_IDLE);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/det_bareiss.sv
// Determinant engine: reads the order N and an N x N signed matrix over the
// i/j/read memory port, runs fraction-free Bareiss elimination with row
// pivoting, and presents the signed determinant with finish/write.
module det_bareiss
  import det_pkg::*;
#(
  parameter int W     = 20,
  parameter int NMAX  = NMAX_DEFAULT,
  parameter int OUT_W = 2 * W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [W-1:0]     i,
  output logic [W-1:0]     j,
  output logic             read,
  output logic             write,
  input  logic [W-1:0]     read_data,
  output logic [OUT_W-1:0] write_data,
  output logic             finish,
  output logic             error
);

  // The default build shares the package index width; other orders derive it.
  localparam int IW = (NMAX == NMAX_DEFAULT) ? IDX_W : idx_width(NMAX);
  localparam int NW = IW + 1;
  localparam int PW = 2 * OUT_W;

  state_e                  state_q, state_d;
  logic [W-1:0]            i_q, i_d, j_q, j_d;
  logic                    read_q, read_d, write_q, write_d;
  logic [OUT_W-1:0]        wdata_q, wdata_d;
  logic                    finish_q, finish_d, error_q, error_d;
  logic                    sign_neg_q, sign_neg_d;
  logic signed [OUT_W-1:0] prev_q, prev_d;
  logic [NW-1:0]           n_q, n_d;
  logic [IW-1:0]           k_q, k_d, ei_q, ei_d, ej_q, ej_d;
  logic [IW-1:0]           swap_r_q, swap_r_d;
  logic signed [OUT_W-1:0] mat_q [NMAX][NMAX];
  logic signed [OUT_W-1:0] mat_d [NMAX][NMAX];

  logic signed [OUT_W-1:0] akk, aij, aik, akj;
  logic signed [PW-1:0]    elim_num;
  logic [NW-1:0]           n_m1;
  logic                    k_last, ei_last, ej_last, i_last, j_last;
  logic                    piv_found;
  logic [IW-1:0]           piv_row;
  logic                    div_start, div_busy, div_done;
  logic [OUT_W-1:0]        div_quo;

  // Operands of the current element update and end-of-range flags.
  always_comb begin
    akk      = mat_q[k_q][k_q];
    aij      = mat_q[ei_q][ej_q];
    aik      = mat_q[ei_q][k_q];
    akj      = mat_q[k_q][ej_q];
    elim_num = PW'(akk) * PW'(aij) - PW'(aik) * PW'(akj);
    n_m1     = n_q - NW'(1);
    k_last   = ({1'b0, k_q} == n_m1);
    ei_last  = ({1'b0, ei_q} == n_m1);
    ej_last  = ({1'b0, ej_q} == n_m1);
    i_last   = (i_q == W'(n_m1));
    j_last   = (j_q == W'(n_m1));
  end

  // First row below the pivot with a nonzero entry in the pivot column.
  always_comb begin
    piv_found = 1'b0;
    piv_row   = '0;
    for (int r = 0; r < NMAX; r++) begin
      if (!piv_found && r > int'(k_q) && r < int'(n_q) && mat_q[IW'(r)][k_q] != '0) begin
        piv_found = 1'b1;
        piv_row   = IW'(r);
      end
    end
  end

  // Main FSM: next state, port outputs and elimination bookkeeping.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    read_d     = read_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    finish_d   = finish_q;
    error_d    = error_q;
    sign_neg_d = sign_neg_q;
    prev_d     = prev_q;
    n_d        = n_q;
    k_d        = k_q;
    ei_d       = ei_q;
    ej_d       = ej_q;
    swap_r_d   = swap_r_q;
    div_start  = 1'b0;
    case (state_q)
      IDLE: state_d = HDR;
      HDR: begin
        if (!read_q) begin
          read_d  = 1'b1;
          write_d = 1'b1;
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_data < W'(HDR_MIN_N) || read_data > W'(NMAX)) begin
            error_d  = 1'b1;
            wdata_d  = '0;
            finish_d = 1'b1;
            write_d  = 1'b1;
            state_d  = DONE;
          end else begin
            n_d     = read_data[NW-1:0];
            i_d     = '0;
            j_d     = '0;
            read_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (i_last && j_last) begin
          read_d  = 1'b0;
          k_d     = '0;
          state_d = PIVOT;
        end else if (j_last) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      PIVOT: begin
        if (k_last) begin
          wdata_d  = sign_neg_q ? -akk : akk;
          finish_d = 1'b1;
          write_d  = 1'b1;
          state_d  = DONE;
        end else if (akk != '0) begin
          ei_d    = k_q + 1'b1;
          ej_d    = k_q + 1'b1;
          state_d = ELIM;
        end else if (piv_found) begin
          swap_r_d = piv_row;
          state_d  = SWAP;
        end else begin
          wdata_d  = '0;
          finish_d = 1'b1;
          write_d  = 1'b1;
          state_d  = DONE;
        end
      end
      SWAP: begin
        sign_neg_d = !sign_neg_q;
        ei_d       = k_q + 1'b1;
        ej_d       = k_q + 1'b1;
        state_d    = ELIM;
      end
      ELIM: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          if (ej_last) begin
            if (ei_last) begin
              prev_d  = akk;
              k_d     = k_q + 1'b1;
              state_d = PIVOT;
            end else begin
              ei_d    = ei_q + 1'b1;
              ej_d    = k_q + 1'b1;
              state_d = ELIM;
            end
          end else begin
            ej_d    = ej_q + 1'b1;
            state_d = ELIM;
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer updates: element capture, row swap, and quotient write-back.
  always_comb begin
    mat_d = mat_q;
    case (state_q)
      LOAD: mat_d[i_q[IW-1:0]][j_q[IW-1:0]] = OUT_W'(signed'(read_data));
      SWAP: begin
        for (int c = 0; c < NMAX; c++) begin
          mat_d[k_q][IW'(c)]      = mat_q[swap_r_q][IW'(c)];
          mat_d[swap_r_q][IW'(c)] = mat_q[k_q][IW'(c)];
        end
      end
      DIV: begin
        if (div_done) begin
          mat_d[ei_q][ej_q] = div_quo;
        end
      end
      default: ;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      finish_q   <= 1'b0;
      error_q    <= 1'b0;
      sign_neg_q <= 1'b0;
      prev_q     <= OUT_W'(1);
      n_q        <= '0;
      k_q        <= '0;
      ei_q       <= '0;
      ej_q       <= '0;
      swap_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      finish_q   <= finish_d;
      error_q    <= error_d;
      sign_neg_q <= sign_neg_d;
      prev_q     <= prev_d;
      n_q        <= n_d;
      k_q        <= k_d;
      ei_q       <= ei_d;
      ej_q       <= ej_d;
      swap_r_q   <= swap_r_d;
    end
  end

  // Matrix buffer; its contents are meaningless until a run loads it.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
  end

  det_div #(
    .OUT_W(OUT_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(elim_num),
    .divisor (prev_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  assign i          = i_q;
  assign j          = j_q;
  assign read       = read_q;
  assign write      = write_q;
  assign write_data = wdata_q;
  assign finish     = finish_q;
  assign error      = error_q;

endmodule
